// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package reaction_pkg;

    localparam int MS_W = 14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_TIME = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DISP_HI    = 2'd0,
        DISP_BLANK = 2'd1,
        DISP_NUM   = 2'd2,
        DISP_CHEAT = 2'd3
    } disp_mode_t;

    // Result reported when the player presses before the stimulus.
    localparam logic [MS_W-1:0] CHEAT_CODE = 14'd9999;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10).
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/reaction_ctrl_if.sv
// Converter handshake bundle between the controller and the binary-to-BCD converter.
// Latency: n/a (wires only).
// Backpressure: bcd_ready low holds off conv_start; bcd_done_tick closes each conversion.
// Signals: bin (value to convert), conv_start (1-cycle start), bcd_ready, bcd_done_tick.
interface reaction_ctrl_if;
    logic [reaction_pkg::MS_W-1:0] bin;
    logic                          conv_start;
    logic                          bcd_ready;
    logic                          bcd_done_tick;

    modport master (
        output bin,
        output conv_start,
        input  bcd_ready,
        input  bcd_done_tick
    );

    modport slave (
        input  bin,
        input  conv_start,
        output bcd_ready,
        output bcd_done_tick
    );
endinterface

// File: rtl/reaction_ctrl_ms_tick_gen.sv
// Millisecond tick generator: mod-TICK_DIV counter with synchronous clear and enable.
// Latency: first tick TICK_DIV enabled cycles after a clear; tick is combinational off the count.
// Backpressure: none; counter holds while en is low.
// Ports: clk, reset, clr (restart count), en (count), tick (one cycle per TICK_DIV).
module ms_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction timer control FSM: random delay, stimulus LED, ms reaction count, result hand-off to BCD converter.
// Latency: outputs registered, one cycle after the causing input; conv_start one cycle after a serviceable request.
// Backpressure: conversion requests coalesce in a pending flag until bcd_ready and the previous conversion's done_tick.
// Ports: clk, reset, clear/start/stop ticks, conv (converter handshake, master side), led, disp_mode, result_valid.
module reaction_ctrl
    import reaction_pkg::*;
#(
    parameter int TICK_DIV     = 100000,
    parameter int MIN_DELAY_MS = 2000,
    parameter int TIMEOUT_MS   = 1000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   start,
    input  logic                   stop,
    reaction_ctrl_if.master        conv,
    output logic                   led,
    output logic [1:0]             disp_mode,
    output logic                   result_valid
);

    localparam logic [MS_W-1:0] MIN_DELAY = MS_W'(MIN_DELAY_MS);
    localparam logic [MS_W-1:0] TIMEOUT   = MS_W'(TIMEOUT_MS);

    state_t          state, state_next;
    logic [15:0]     lfsr;
    logic [MS_W-1:0] delay_ms, delay_next;
    logic [MS_W-1:0] ms_reg, ms_next, ms_inc;
    logic            cheat, cheat_next;
    logic            req;
    logic            tick;
    logic            led_next;
    disp_mode_t      disp_next;

    logic            pending;
    logic            busy;
    logic            final_issued;
    logic            issue;

    // Restarting the divider on every state change makes the first tick land
    // exactly TICK_DIV cycles after entry.
    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (state_next != state),
        .en    ((state == ST_WAIT) || (state == ST_TIME)),
        .tick  (tick)
    );

    assign ms_inc = ms_reg + MS_W'(1);

    always_comb begin
        state_next = state;
        delay_next = delay_ms;
        ms_next    = ms_reg;
        cheat_next = cheat;
        req        = 1'b0;

        if (clear) begin
            state_next = ST_IDLE;
            ms_next    = '0;
            cheat_next = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        delay_next = MIN_DELAY + {1'b0, lfsr[12:0]};
                        cheat_next = 1'b0;
                        state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (stop) begin
                        ms_next    = CHEAT_CODE;
                        cheat_next = 1'b1;
                        req        = 1'b1;
                        state_next = ST_DONE;
                    end else if (tick) begin
                        delay_next = delay_ms - MS_W'(1);
                        if (delay_ms <= MS_W'(1)) begin
                            ms_next    = '0;
                            req        = 1'b1;
                            state_next = ST_TIME;
                        end
                    end
                end
                ST_TIME: begin
                    // A stop coinciding with a tick freezes the count before the increment.
                    if (stop) begin
                        req        = 1'b1;
                        state_next = ST_DONE;
                    end else if (tick) begin
                        req = 1'b1;
                        if (ms_inc >= TIMEOUT) begin
                            ms_next    = TIMEOUT;
                            state_next = ST_DONE;
                        end else begin
                            ms_next = ms_inc;
                        end
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        led_next  = (state_next == ST_TIME);
        disp_next = DISP_HI;
        case (state_next)
            ST_IDLE: disp_next = DISP_HI;
            ST_WAIT: disp_next = DISP_BLANK;
            ST_TIME: disp_next = DISP_NUM;
            ST_DONE: disp_next = cheat_next ? DISP_CHEAT : DISP_NUM;
            default: disp_next = DISP_HI;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            lfsr      <= LFSR_SEED;
            delay_ms  <= '0;
            ms_reg    <= '0;
            cheat     <= 1'b0;
            led       <= 1'b0;
            disp_mode <= DISP_HI;
        end else begin
            state     <= state_next;
            lfsr      <= lfsr_step(lfsr);
            delay_ms  <= delay_next;
            ms_reg    <= ms_next;
            cheat     <= cheat_next;
            led       <= led_next;
            disp_mode <= disp_next;
        end
    end

    // busy spans issue to done_tick so a second start can never overlap a
    // conversion, including one left in flight across a clear.
    assign issue = pending && conv.bcd_ready && !busy && !clear;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending         <= 1'b0;
            busy            <= 1'b0;
            final_issued    <= 1'b0;
            conv.conv_start <= 1'b0;
            conv.bin        <= '0;
            result_valid    <= 1'b0;
        end else begin
            conv.conv_start <= issue;
            if (issue) begin
                conv.bin <= ms_reg;
            end

            if (issue) begin
                busy <= 1'b1;
            end else if (conv.bcd_done_tick) begin
                busy <= 1'b0;
            end

            // A request landing on the issue edge keeps pending set so the newer value is sent next.
            if (clear) begin
                pending <= 1'b0;
            end else if (req) begin
                pending <= 1'b1;
            end else if (issue) begin
                pending <= 1'b0;
            end

            // Only a conversion started from DONE carries the final value.
            if (clear) begin
                final_issued <= 1'b0;
            end else if (issue) begin
                final_issued <= (state == ST_DONE);
            end

            if (clear) begin
                result_valid <= 1'b0;
            end else if ((state == ST_DONE) && final_issued && busy && conv.bcd_done_tick) begin
                result_valid <= 1'b1;
            end
        end
    end

endmodule
